// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: memory-stage FSM states and SRAM geometry.
package arm_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_LO,
    MEM_HI,
    MEM_DONE
  } mem_state_e;

  localparam int SRAM_ADDR_W = 18;
  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one SRAM half-word phase; last_o flags the final cycle.
module sram_wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [3:0] limit_i,
  output logic       last_o
);

  logic [3:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = 4'd0;
    else if (en_i) cnt_d = cnt_q + 4'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_stage_sram.sv
// ARM memory-access stage: splits each 32-bit load/store into two 16-bit
// accesses on an asynchronous SRAM, stalling the pipeline via ready.
module mem_stage_sram
  import arm_pkg::*;
#(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            ALU_Res,
  input  logic [31:0]            Val_Rm,
  output logic [31:0]            Data_Mem,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic [15:0]            SRAM_DQ_OUT,
  output logic                   SRAM_DQ_OE,
  input  logic [15:0]            SRAM_DQ_IN,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N
);

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  mem_state_e  state_q, state_d;
  logic        is_rd_q, is_rd_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] data_q, data_d;

  logic        req, in_phase, last;
  logic [31:0] offset;
  logic        unused_offset;

  assign req           = MEM_R_EN | MEM_W_EN;
  assign offset        = ALU_Res - ADDR_BASE;
  assign unused_offset = ^{offset[31:19], offset[1:0]};
  assign in_phase      = (state_q == MEM_LO) || (state_q == MEM_HI);
  assign Data_Mem      = data_q;
  assign ready         = (state_q == MEM_DONE) || ((state_q == MEM_IDLE) && !req);

  sram_wait_counter u_wait (
    .clk     (clk),
    .rst_n   (rst),
    .clear_i (!in_phase || last),
    .en_i    (in_phase),
    .limit_i (WAIT_LIM),
    .last_o  (last)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    is_rd_d     = is_rd_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    data_d      = data_q;
    SRAM_ADDR   = '0;
    SRAM_DQ_OUT = 16'h0;
    SRAM_DQ_OE  = 1'b0;
    SRAM_WE_N   = 1'b1;
    SRAM_OE_N   = 1'b1;

    case (state_q)
      MEM_IDLE: begin
        if (req) begin
          is_rd_d = MEM_R_EN;  // a read wins when both enables are set
          word_d  = offset[18:2];
          wdata_d = Val_Rm;
          state_d = MEM_LO;
        end
      end
      MEM_LO, MEM_HI: begin
        SRAM_ADDR = {word_q, state_q == MEM_HI};
        if (is_rd_q) begin
          SRAM_OE_N = 1'b0;
          if (last) begin
            if (state_q == MEM_LO) lo_d   = SRAM_DQ_IN;
            else                   data_d = {SRAM_DQ_IN, lo_q};
          end
        end else begin
          SRAM_DQ_OE  = 1'b1;
          SRAM_DQ_OUT = (state_q == MEM_HI) ? wdata_q[31:16] : wdata_q[15:0];
          // Strobe rises on the last cycle so it precedes the address change.
          SRAM_WE_N   = last;
        end
        if (last) state_d = (state_q == MEM_LO) ? MEM_HI : MEM_DONE;
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MEM_IDLE;
      is_rd_q <= 1'b0;
      word_q  <= 17'd0;
      wdata_q <= 32'd0;
      lo_q    <= 16'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      is_rd_q <= is_rd_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram (W=1) with a one-cycle-latency SRAM model.
module tb_mem_stage_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_Res, Val_Rm;
  logic [31:0] Data_Mem;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_OUT, SRAM_DQ_IN;
  logic        SRAM_DQ_OE, SRAM_WE_N, SRAM_OE_N;

  int errors = 0;
  int checks = 0;

  logic [15:0] sram [0:63];

  mem_stage_sram #(.WAIT_CYCLES(1), .ADDR_BASE(32'd1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .MEM_R_EN    (MEM_R_EN),
    .MEM_W_EN    (MEM_W_EN),
    .ALU_Res     (ALU_Res),
    .Val_Rm      (Val_Rm),
    .Data_Mem    (Data_Mem),
    .ready       (ready),
    .SRAM_ADDR   (SRAM_ADDR),
    .SRAM_DQ_OUT (SRAM_DQ_OUT),
    .SRAM_DQ_OE  (SRAM_DQ_OE),
    .SRAM_DQ_IN  (SRAM_DQ_IN),
    .SRAM_WE_N   (SRAM_WE_N),
    .SRAM_OE_N   (SRAM_OE_N)
  );

  always #5 clk = ~clk;

  // SRAM model: registered read data, write on strobe low; preloaded during reset.
  always @(posedge clk) begin
    if (!rst) begin
      sram[4] <= 16'hBEEF;
      sram[5] <= 16'hDEAD;
    end else if (!SRAM_WE_N && SRAM_DQ_OE) begin
      sram[SRAM_ADDR[5:0]] <= SRAM_DQ_OUT;
    end
    SRAM_DQ_IN <= sram[SRAM_ADDR[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one W=1 access: request applied after a rising edge, cycles 0..5 checked.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_dm, input string tag);
    logic [31:0] word;
    logic [17:0] lo_a, hi_a;
    word = (a - 32'd1024) >> 2;
    lo_a = {word[16:0], 1'b0};
    hi_a = {word[16:0], 1'b1};
    @(posedge clk);
    #1;
    MEM_R_EN = r;
    MEM_W_EN = w;
    ALU_Res  = a;
    Val_Rm   = d;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d_ready", tag, c), {31'd0, ready}, {31'd0, c == 5});
      if (c == 0 || c == 5) begin
        check($sformatf("%s_c%0d_addr", tag, c), {14'd0, SRAM_ADDR}, 32'd0);
        check($sformatf("%s_c%0d_oe_n", tag, c), {31'd0, SRAM_OE_N}, 32'd1);
        check($sformatf("%s_c%0d_we_n", tag, c), {31'd0, SRAM_WE_N}, 32'd1);
        check($sformatf("%s_c%0d_dq_oe", tag, c), {31'd0, SRAM_DQ_OE}, 32'd0);
      end else begin
        check($sformatf("%s_c%0d_addr", tag, c), {14'd0, SRAM_ADDR},
              {14'd0, (c <= 2) ? lo_a : hi_a});
        check($sformatf("%s_c%0d_oe_n", tag, c), {31'd0, SRAM_OE_N}, {31'd0, !r});
        check($sformatf("%s_c%0d_dq_oe", tag, c), {31'd0, SRAM_DQ_OE}, {31'd0, !r});
        check($sformatf("%s_c%0d_we_n", tag, c), {31'd0, SRAM_WE_N},
              {31'd0, r || c == 2 || c == 4});
        if (!r)
          check($sformatf("%s_c%0d_dq_out", tag, c), {16'd0, SRAM_DQ_OUT},
                {16'd0, (c <= 2) ? d[15:0] : d[31:16]});
      end
    end
    check({tag, "_data_mem"}, Data_Mem, exp_dm);
  endtask

  initial begin
    rst = 1'b0;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    ALU_Res  = 32'd0;
    Val_Rm   = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_data_mem", Data_Mem, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
    check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check("rst_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ready}, 32'd1);
      check("idle_we_n", {31'd0, SRAM_WE_N}, 32'd1);
      check("idle_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
      check("idle_dq_oe", {31'd0, SRAM_DQ_OE}, 32'd0);
    end

    access(1'b1, 1'b0, 32'd1032, 32'd0, 32'hDEADBEEF, "read");
    MEM_R_EN = 1'b0;

    access(1'b0, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF, "write");
    MEM_W_EN = 1'b0;
    check("write_sram2", {16'd0, sram[2]}, 32'h5678);
    check("write_sram3", {16'd0, sram[3]}, 32'h1234);

    access(1'b0, 1'b1, 32'd1100, 32'hCAFEF00D, 32'hDEADBEEF, "b2b_wr");
    access(1'b1, 1'b0, 32'd1100, 32'd0, 32'hCAFEF00D, "b2b_rd");
    MEM_R_EN = 1'b0;

    @(posedge clk);
    #1;
    MEM_R_EN = 1'b1;
    ALU_Res  = 32'd1032;
    repeat (4) @(negedge clk);
    check("rstmid_hi_addr", {14'd0, SRAM_ADDR}, 32'd5);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_addr", {14'd0, SRAM_ADDR}, 32'd0);
    check("rstmid_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
    check("rstmid_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check("rstmid_dq_oe", {31'd0, SRAM_DQ_OE}, 32'd0);
    check("rstmid_data_mem", Data_Mem, 32'd0);
    check("rstmid_ready_req", {31'd0, ready}, 32'd0);
    MEM_R_EN = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstrel_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    check("rstrel_ready2", {31'd0, ready}, 32'd1);
    check("rstrel_oe_n", {31'd0, SRAM_OE_N}, 32'd1);

    access(1'b1, 1'b1, 32'd1032, 32'h11112222, 32'hDEADBEEF, "both");
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    check("both_sram4_intact", {16'd0, sram[4]}, 32'hBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
